// File: rtl/mem_access_unit.sv
// Multicycle load/store initiator: holds a memory strobe for LATENCY cycles, then returns
// a single-cycle response with extended load data or an out-of-range error.
module mem_access_unit #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [17:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [17:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte,
  input  logic [31:0] mem_read_data
);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("mem_access_unit: LATENCY must be >= 1");
    end
  endgenerate

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [18:0]   DEPTH_W  = 19'(DEPTH);

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          write_q;
  logic          signed_q;
  logic          addr_err;
  logic [31:0]   load_data;

  assign req_ready = (state == IDLE);
  // Compare with one spare bit so every one of the 18 address bits participates.
  assign addr_err  = ({1'b0, req_addr} >= DEPTH_W);

  // mem_byte still carries the latched byte flag of the current access.
  assign load_data = mem_byte ? {{24{signed_q & mem_read_data[7]}}, mem_read_data[7:0]}
                              : mem_read_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'd0;
      resp_error     <= 1'b0;
      mem_address    <= 18'd0;
      mem_write_data <= 32'd0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            if (addr_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state          <= ACCESS;
              mem_address    <= req_addr;
              mem_byte       <= req_byte;
              mem_write_data <= (req_byte && req_write) ? {24'd0, req_wdata[7:0]} : req_wdata;
              mem_write      <= req_write;
              mem_read       <= !req_write;
              count          <= CNT_LOAD;
            end
          end
        end
        ACCESS: begin
          if (count == '0) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= write_q ? 32'd0 : load_data;
          end else begin
            count <= count - 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model of memory contents and response timing,
// checked every cycle, plus directed literal checks and randomized traffic.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
  logic [17:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_error, mem_read, mem_write, mem_byte;
  logic [31:0] resp_rdata, mem_write_data, mem_read_data;
  logic [17:0] mem_address;

  mem_access_unit #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte(mem_byte), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Environment memory (what the DUT actually talks to) and the model's own view of it.
  logic [31:0] env_mem [0:255];
  logic [31:0] mdl_mem [0:255];
  assign mem_read_data = env_mem[mem_address[7:0]];

  // Expected outputs after the most recent rising edge.
  logic        exp_ready = 1'b1, exp_valid = 1'b0, exp_rd = 1'b0, exp_wr = 1'b0, exp_err = 1'b0;
  logic        exp_byte = 1'b0;
  logic [31:0] exp_rdata = '0, exp_wd = '0;
  logic [17:0] exp_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: decides acceptance from its own notion of idleness, then derives outputs
  // purely from the distance to the acceptance edge.
  initial begin : model
    int e0, resp_at;
    bit active, m_err, m_w;
    logic [31:0] pend, d;
    logic [7:0]  a;
    active = 0; m_err = 0; m_w = 0; pend = 0; e0 = 0; resp_at = 0;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      env_mem[i] = d;
      mdl_mem[i] = d;
    end
    env_mem[7] = 32'h123456F0;
    mdl_mem[7] = 32'h123456F0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset && mem_write === 1'b1) begin
        if (mem_byte) env_mem[mem_address[7:0]][7:0] = mem_write_data[7:0];
        else          env_mem[mem_address[7:0]]      = mem_write_data;
      end
      if (reset) begin
        active = 0;
        exp_ready = 1; exp_valid = 0; exp_rd = 0; exp_wr = 0; exp_err = 0;
        exp_rdata = 0; exp_addr = 0; exp_wd = 0; exp_byte = 0;
      end else begin
        if (exp_ready && req_valid) begin
          e0 = cyc; active = 1; m_w = req_write;
          m_err = (req_addr >= 18'(DEPTH));
          pend = 0;
          if (!m_err) begin
            a = req_addr[7:0];
            exp_addr = req_addr;
            exp_byte = req_byte;
            exp_wd   = (req_byte && req_write) ? {24'h0, req_wdata[7:0]} : req_wdata;
            if (req_write) begin
              if (req_byte) mdl_mem[a][7:0] = req_wdata[7:0];
              else          mdl_mem[a]      = req_wdata;
            end else begin
              d = mdl_mem[a];
              if (!req_byte)              pend = d;
              else if (req_signed && d[7]) pend = {24'hFFFFFF, d[7:0]};
              else                         pend = {24'h0, d[7:0]};
            end
          end
          resp_at = m_err ? e0 : e0 + LAT;
        end
        exp_valid = active && (cyc == resp_at);
        if (exp_valid) begin
          exp_rdata = pend;
          exp_err   = m_err;
        end
        exp_rd    = active && !m_err && !m_w && (cyc < resp_at);
        exp_wr    = active && !m_err &&  m_w && (cyc < resp_at);
        exp_ready = !active || (cyc > resp_at);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en && !reset) begin
        chk("req_ready", req_ready, exp_ready);
        chk("resp_valid", resp_valid, exp_valid);
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_error", resp_error, exp_err);
        chk("mem_read", mem_read, exp_rd);
        chk("mem_write", mem_write, exp_wr);
        chk("mem_address", mem_address, exp_addr);
        chk("mem_write_data", mem_write_data, exp_wd);
        chk("mem_byte", mem_byte, exp_byte);
      end
    end
  end

  task automatic issue(input logic w, input logic b, input logic s, input logic [17:0] a,
                       input logic [31:0] d, input bit garble, output int acc, output int busy);
    bit done;
    done = 0; busy = 0; acc = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      if (req_ready) begin
        req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        acc = cyc;
        done = 1;
      end else begin
        busy++;
        if (garble) begin
          req_write = 1'($urandom); req_byte = 1'($urandom); req_signed = 1'($urandom);
          req_addr = 18'($urandom); req_wdata = $urandom;
        end else begin
          req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = d;
        end
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout got busy %0d want accept", busy);
    end
  endtask

  task automatic wait_resp(input string nm, input int lat, input logic [31:0] rd,
                           input logic er, input int strobes);
    int s;
    bit got;
    s = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1;
        chk({nm, "_lat"}, i, lat);
        chk({nm, "_rdata"}, resp_rdata, rd);
        chk({nm, "_err"}, resp_error, er);
        chk({nm, "_strobes"}, s, strobes);
      end else if (mem_read || mem_write) begin
        s++;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout got no resp_valid want resp_valid", nm);
    end
  endtask

  initial begin : main
    int ac1, ac2, bz;
    logic [17:0] a;
    int r;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_error", resp_error, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_byte", mem_byte, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk_en = 1;

    issue(1, 0, 0, 18'd5, 32'hDEADBEEF, 0, ac1, bz); req_valid = 0;
    wait_resp("st5", LAT, 32'h0, 0, 2);
    issue(0, 0, 0, 18'd5, 32'h0, 0, ac1, bz); req_valid = 0;
    wait_resp("ld5", LAT, 32'hDEADBEEF, 0, 2);
    issue(0, 1, 0, 18'd7, 32'h0, 0, ac1, bz); req_valid = 0;
    wait_resp("ldbu7", LAT, 32'h000000F0, 0, 2);
    issue(0, 1, 1, 18'd7, 32'h0, 0, ac1, bz); req_valid = 0;
    wait_resp("ldbs7", LAT, 32'hFFFFFFF0, 0, 2);
    issue(0, 0, 1, 18'd7, 32'h0, 0, ac1, bz); req_valid = 0;
    wait_resp("ldw7", LAT, 32'h123456F0, 0, 2);
    issue(1, 1, 0, 18'd3, 32'h112233AB, 0, ac1, bz); req_valid = 0;
    wait_resp("stb3", LAT, 32'h0, 0, 2);
    chk("stb3_wdata", mem_write_data, 32'h000000AB);
    chk("stb3_byte", mem_byte, 1);
    issue(0, 0, 0, 18'd256, 32'h0, 0, ac1, bz); req_valid = 0;
    wait_resp("oor256", 0, 32'h0, 1, 0);
    issue(0, 0, 0, 18'h3FFFF, 32'h0, 0, ac1, bz); req_valid = 0;
    wait_resp("oor3ffff", 0, 32'h0, 1, 0);
    issue(0, 0, 0, 18'd255, 32'h0, 0, ac1, bz); req_valid = 0;
    wait_resp("ld255", LAT, mdl_mem[255], 0, 2);

    issue(0, 0, 0, 18'd7, 32'h0, 0, ac1, bz);
    issue(0, 0, 0, 18'd5, 32'h0, 1, ac2, bz);
    req_valid = 0;
    chk("b2b_gap", ac2 - ac1, LAT + 2);
    chk("b2b_busy", bz, LAT + 1);
    repeat (LAT + 2) @(negedge clk);

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 18'(DEPTH + $urandom_range(0, 1000));
      else if (r == 1) a = ($urandom_range(0, 1) != 0) ? 18'h3FFFF : 18'd255;
      else             a = 18'($urandom_range(0, DEPTH - 1));
      issue(1'($urandom), 1'($urandom), 1'($urandom), a, $urandom, 1'($urandom), ac1, bz);
      if ($urandom_range(0, 2) != 0) begin
        req_valid = 0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    req_valid = 0;
    repeat (LAT + 3) @(negedge clk);

    issue(0, 0, 0, 18'd9, 32'h0, 0, ac1, bz); req_valid = 0;
    @(posedge clk);
    #1;
    chk("pre_rst_read", mem_read, 1);
    reset = 1'b1;
    #1;
    chk("async_read_drop", mem_read, 0);
    chk("async_valid", resp_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_addr", mem_address, 0);
    chk("post_rst_rdata", resp_rdata, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_resp", resp_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
